// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_arb_pkg
//  Brief   : Shared arbitration-mode constants and select-width helper.
//  Rev     : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width that never collapses to zero bits, even for tiny N.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_reg_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Brief   : First set bit of a valid vector, searching circularly from ptr.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    // Scan offsets from the far end so the nearest hit to ptr is written last.
    always_comb begin
        logic [SEL_W-1:0] w_j;
        w_j     = '0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = SEL_W'((int'(i_ptr) + k) % N);
            if (i_valid[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_arb_reg
//  Brief   : N-way valid/ready arbiter-mux with a registered output stage.
//  Rev     : 1.0  initial release
// ============================================================================
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int W     = 32,
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N),
    parameter int MODE  = MODE_FIXED
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [N-1:0]     req_valid_in,
    input  logic [N*W-1:0]   data_in,
    output logic [N-1:0]     req_ready_out,
    input  logic             force_en_in,
    input  logic [SEL_W-1:0] select_in,
    output logic [W-1:0]     data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [SEL_W-1:0] grant_out
);

    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(N - 1);

    logic [W-1:0]     r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_ok;
    logic             w_arb_found;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_force_hit;
    logic             w_cand_valid;
    logic [SEL_W-1:0] w_cand_idx;
    logic             w_take;
    logic [W-1:0]     w_sel_data;

    assign w_load_ok = !r_valid || ready_in;

    // In fixed-priority mode r_ptr is held at 0, giving lowest-index-wins.
    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_valid (req_valid_in),
        .i_ptr   (r_ptr),
        .o_found (w_arb_found),
        .o_idx   (w_arb_idx)
    );

    // Out-of-range select values match no channel and so grant nothing.
    always_comb begin
        w_force_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (select_in == SEL_W'(i)) begin
                w_force_hit = req_valid_in[i];
            end
        end
    end

    assign w_cand_valid = force_en_in ? w_force_hit : w_arb_found;
    assign w_cand_idx   = force_en_in ? select_in   : w_arb_idx;
    assign w_take       = w_load_ok && w_cand_valid && !reset_in;

    always_comb begin
        w_sel_data    = '0;
        req_ready_out = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cand_idx == SEL_W'(i)) begin
                w_sel_data       = data_in[i*W +: W];
                req_ready_out[i] = w_take;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
        end else if (w_take) begin
            r_data  <= w_sel_data;
            r_valid <= 1'b1;
            r_grant <= w_cand_idx;
        end else if (w_load_ok) begin
            r_valid <= 1'b0;
        end
    end

    generate
        if (MODE == MODE_RR) begin : g_rr_ptr
            // Forced transfers do not disturb the fairness rotation.
            always_ff @(posedge clk_in) begin
                if (reset_in) begin
                    r_ptr <= '0;
                end else if (w_take && !force_en_in) begin
                    r_ptr <= (w_cand_idx == c_last_idx) ? '0 : w_cand_idx + 1'b1;
                end
            end
        end else begin : g_fixed_ptr
            always_ff @(posedge clk_in) begin
                r_ptr <= '0;
            end
        end
    endgenerate

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign grant_out = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mux_arb_reg
//  Brief   : Checks three mux_arb_reg configurations against a reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mux_arb_reg;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]   rv   [NI];
    logic [127:0] din  [NI];
    logic         fen  [NI];
    logic [1:0]   sel  [NI];
    logic         rdy  [NI];

    logic [3:0]   rro  [NI];
    logic [31:0]  dout [NI];
    logic         vout [NI];
    logic [1:0]   gout [NI];

    logic [3:0]  rro0, rro1;
    logic [2:0]  rro2;
    logic [31:0] dout0, dout1, dout2;
    logic        vout0, vout1, vout2;
    logic [1:0]  gout0, gout1, gout2;

    always_comb begin
        rro[0]  = rro0;  rro[1]  = rro1;  rro[2]  = {1'b0, rro2};
        dout[0] = dout0; dout[1] = dout1; dout[2] = dout2;
        vout[0] = vout0; vout[1] = vout1; vout[2] = vout2;
        gout[0] = gout0; gout[1] = gout1; gout[2] = gout2;
    end

    mux_arb_reg #(.W(32), .N(4), .MODE(0)) dut0 (
        .clk_in(clk), .reset_in(rst), .req_valid_in(rv[0]), .data_in(din[0]),
        .req_ready_out(rro0), .force_en_in(fen[0]), .select_in(sel[0]),
        .data_out(dout0), .valid_out(vout0), .ready_in(rdy[0]), .grant_out(gout0));

    mux_arb_reg #(.W(32), .N(4), .MODE(1)) dut1 (
        .clk_in(clk), .reset_in(rst), .req_valid_in(rv[1]), .data_in(din[1]),
        .req_ready_out(rro1), .force_en_in(fen[1]), .select_in(sel[1]),
        .data_out(dout1), .valid_out(vout1), .ready_in(rdy[1]), .grant_out(gout1));

    mux_arb_reg #(.W(32), .N(3), .MODE(1)) dut2 (
        .clk_in(clk), .reset_in(rst), .req_valid_in(rv[2][2:0]), .data_in(din[2][95:0]),
        .req_ready_out(rro2), .force_en_in(fen[2]), .select_in(sel[2]),
        .data_out(dout2), .valid_out(vout2), .ready_in(rdy[2]), .grant_out(gout2));

    // Reference model state: the word sitting in the output stage and the RR pointer.
    bit          m_valid [NI];
    logic [31:0] m_data  [NI];
    int          m_grant [NI];
    int          m_ptr   [NI];

    int checks   = 0;
    int failures = 0;

    function automatic int nch(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit is_rr(input int k);
        return k != 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: check accept strobes before the edge, advance model, check registers after.
    task automatic step();
        bit          n_valid [NI];
        logic [31:0] n_data  [NI];
        int          n_grant [NI];
        int          n_ptr   [NI];
        #2;
        for (int k = 0; k < NI; k++) begin
            int   n;
            int   start;
            int   g;
            bit   found;
            bit   ld;
            bit   take;
            logic [3:0] exp_rr;
            n     = nch(k);
            found = 1'b0;
            g     = 0;
            ld    = !m_valid[k] || rdy[k];
            if (fen[k]) begin
                if (int'(sel[k]) < n && rv[k][sel[k]]) begin
                    found = 1'b1;
                    g     = int'(sel[k]);
                end
            end else begin
                start = is_rr(k) ? m_ptr[k] : 0;
                for (int o = 0; o < n; o++) begin
                    if (!found && rv[k][(start + o) % n]) begin
                        found = 1'b1;
                        g     = (start + o) % n;
                    end
                end
            end
            take   = ld && found && !rst;
            exp_rr = take ? 4'(1 << g) : 4'b0000;
            chk($sformatf("req_ready[%0d]", k), 64'(rro[k]), 64'(exp_rr));

            n_valid[k] = m_valid[k];
            n_data[k]  = m_data[k];
            n_grant[k] = m_grant[k];
            n_ptr[k]   = m_ptr[k];
            if (rst) begin
                n_valid[k] = 1'b0;
                n_data[k]  = '0;
                n_grant[k] = 0;
                n_ptr[k]   = 0;
            end else if (take) begin
                n_valid[k] = 1'b1;
                n_data[k]  = din[k][g*32 +: 32];
                n_grant[k] = g;
                if (is_rr(k) && !fen[k]) n_ptr[k] = (g + 1) % n;
            end else if (ld) begin
                n_valid[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            m_valid[k] = n_valid[k];
            m_data[k]  = n_data[k];
            m_grant[k] = n_grant[k];
            m_ptr[k]   = n_ptr[k];
            chk($sformatf("valid_out[%0d]", k), 64'(vout[k]), 64'(m_valid[k]));
            chk($sformatf("data_out[%0d]", k),  64'(dout[k]), 64'(m_data[k]));
            chk($sformatf("grant_out[%0d]", k), 64'(gout[k]), 64'(m_grant[k]));
        end
    endtask

    task automatic all_idle_valid();
        for (int k = 0; k < NI; k++) begin
            rv[k]  = 4'hF;
            fen[k] = 1'b0;
            sel[k] = 2'd0;
            rdy[k] = 1'b1;
            for (int i = 0; i < 4; i++) din[k][i*32 +: 32] = 32'h0000_0A00 + 32'(i) * 32'h100;
        end
    endtask

    initial begin
        int exp_rr_seq [6];
        exp_rr_seq = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < NI; k++) begin
            m_valid[k] = 1'b0; m_data[k] = '0; m_grant[k] = 0; m_ptr[k] = 0;
        end

        // Reset held two cycles with every channel requesting.
        all_idle_valid();
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(vout[0]), 64'd0);
        chk("rst_data", 64'(dout[0]), 64'd0);
        chk("rst_grant", 64'(gout[0]), 64'd0);
        chk("rst_ready", 64'(rro[1]), 64'd0);

        // First word after reset, then fixed priority on dut0 and RR rotation on dut2.
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) chk("first_word", 64'(dout[0]), 64'h0000_0A00);
            else if (c <= 3) begin
                chk("fixed_grant", 64'(gout[0]), 64'd1);
                chk("fixed_ready", 64'(rro[0]), 64'b0010);
            end
            chk($sformatf("rr3_grant_%0d", c), 64'(gout[2]), 64'(exp_rr_seq[c]));
            if (c == 0) rv[0] = 4'b1010;
        end

        // Back-pressure on dut0 holding a ch2 word.
        rv[0] = 4'b0100;
        din[0][64 +: 32] = 32'hDEAD_BEEF;
        step();
        rdy[0] = 1'b0;
        rv[0]  = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_data", 64'(dout[0]), 64'hDEAD_BEEF);
            chk("bp_grant", 64'(gout[0]), 64'd2);
            chk("bp_valid", 64'(vout[0]), 64'd1);
            chk("bp_ready", 64'(rro[0]), 64'd0);
        end
        rdy[0] = 1'b1;
        step();
        chk("bp_nobubble_valid", 64'(vout[0]), 64'd1);
        chk("bp_nobubble_data", 64'(dout[0]), 64'h0000_0A00);

        // Reset mid-operation: dut0 stalled with a word, dut1 would otherwise accept.
        rdy[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 64'(vout[0]), 64'd0);
        chk("midrst_ready", 64'(rro[1]), 64'd0);
        rst    = 1'b0;
        rdy[0] = 1'b1;
        step();
        chk("midrst_ptr0", 64'(gout[1]), 64'd0);

        // Force override on dut1 with its pointer at 1.
        fen[1] = 1'b1;
        sel[1] = 2'd3;
        step();
        chk("force_grant", 64'(gout[1]), 64'd3);
        sel[1] = 2'd2;
        rv[1]  = 4'b1011;
        step();
        chk("force_invalid_valid", 64'(vout[1]), 64'd0);
        fen[1] = 1'b0;
        rv[1]  = 4'hF;
        step();
        chk("force_ptr_kept", 64'(gout[1]), 64'd1);

        // Randomized traffic, including out-of-range forced selects on the N=3 instance.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NI; k++) begin
                rv[k]  = 4'($urandom);
                din[k] = {$urandom, $urandom, $urandom, $urandom};
                rdy[k] = ($urandom_range(0, 3) != 0);
                fen[k] = ($urandom_range(0, 3) == 0);
                sel[k] = 2'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
